// File: rtl/dr_logic_stage.sv
// Clocked dual-rail logic stage: captures a complete operand pair, applies a
// runtime-selected bitwise op and holds the result under a four-phase handshake.
module dr_logic_stage #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_1,
    input  logic [WIDTH-1:0] a_0,
    input  logic [WIDTH-1:0] b_1,
    input  logic [WIDTH-1:0] b_0,
    input  logic [1:0]       op,
    output logic             in_ack,
    output logic [WIDTH-1:0] z_1,
    output logic [WIDTH-1:0] z_0,
    output logic             z_cd,
    input  logic             out_ack,
    output logic             err,
    output logic [1:0]       err_code,
    input  logic             err_clr,
    output logic [CNT_W-1:0] count
);

    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FULL  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] apply_op(input logic [1:0] sel,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (sel)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a ^ b);
        endcase
    endfunction

    function automatic logic [TMR_W-1:0] timer_inc(input logic [TMR_W-1:0] t);
        if (TIMEOUT == 0)
            return '0;
        if (t >= TMR_W'(TIMEOUT))
            return t;
        return t + TMR_W'(1);
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   z1_q, z1_d;
    logic [WIDTH-1:0]   z0_q, z0_d;
    logic               in_ack_q, in_ack_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TMR_W-1:0]   timer_q, timer_d;

    logic               word_spacer;
    logic               word_complete;
    logic               word_partial;
    logic               word_illegal;
    logic               capture;
    logic               release_z;
    logic               ack_clr;
    logic               timer_run;
    logic               tmo_hit;
    logic               new_err;
    logic [1:0]         new_code;
    logic [WIDTH-1:0]   result;

    // Operand word classification; an illegal bit makes the word partial.
    assign word_spacer   = ~|(a_1 | a_0 | b_1 | b_0);
    assign word_complete = (&(a_1 ^ a_0)) & (&(b_1 ^ b_0));
    assign word_partial  = ~word_spacer & ~word_complete;
    assign word_illegal  = |(a_1 & a_0) | |(b_1 & b_0);
    assign result        = apply_op(op, a_1, b_1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (word_complete && !in_ack_q) state_d = S_FULL;
            S_FULL:  if (out_ack) state_d = S_DRAIN;
            S_DRAIN: if (!out_ack && !in_ack_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Input-side release is decoupled from the output side, so ack_clr and
    // release_z may fire on the same edge.
    always_comb begin
        capture   = (state_q == S_IDLE) && word_complete && !in_ack_q;
        release_z = (state_q == S_FULL) && out_ack;
        ack_clr   = (state_q != S_IDLE) && in_ack_q && word_spacer;
        timer_run = (state_q == S_IDLE) && word_partial;
    end

    always_comb begin
        z1_d     = z1_q;
        z0_d     = z0_q;
        in_ack_d = in_ack_q;
        count_d  = count_q;
        if (capture) begin
            z1_d     = result;
            z0_d     = ~result;
            in_ack_d = 1'b1;
        end
        if (release_z) begin
            z1_d    = '0;
            z0_d    = '0;
            count_d = count_q + CNT_W'(1);
        end
        if (ack_clr)
            in_ack_d = 1'b0;
    end

    always_comb begin
        timer_d = timer_run ? timer_inc(timer_q) : '0;
        tmo_hit = (TIMEOUT > 0) && timer_run && (timer_d == TMR_W'(TIMEOUT));
    end

    // First cause sticks; a fresh error on the clearing edge wins over err_clr.
    always_comb begin
        new_err    = word_illegal || tmo_hit;
        new_code   = word_illegal ? 2'b01 : 2'b10;
        err_d      = err_q;
        err_code_d = err_code_q;
        if (new_err && (!err_q || err_clr)) begin
            err_d      = 1'b1;
            err_code_d = new_code;
        end else if (err_clr) begin
            err_d      = 1'b0;
            err_code_d = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z1_q       <= '0;
            z0_q       <= '0;
            in_ack_q   <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            count_q    <= '0;
            timer_q    <= '0;
        end else begin
            z1_q       <= z1_d;
            z0_q       <= z0_d;
            in_ack_q   <= in_ack_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            count_q    <= count_d;
            timer_q    <= timer_d;
        end
    end

    assign z_1      = z1_q;
    assign z_0      = z0_q;
    assign z_cd     = &(z1_q ^ z0_q);
    assign in_ack   = in_ack_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign count    = count_q;

endmodule

// File: tb/tb_dr_logic_stage.sv
// Bench for dr_logic_stage: directed vector table, corner sequences and a
// randomized run against a protocol-level reference model.
module tb_dr_logic_stage;

    localparam int W  = 4;
    localparam int TO = 15;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a_1, a_0, b_1, b_0;
    logic [1:0]   op;
    logic         out_ack, err_clr;

    logic         in_ack, z_cd, err;
    logic [W-1:0] z_1, z_0;
    logic [1:0]   err_code;
    logic [15:0]  count;

    logic         in_ack_t0, z_cd_t0, err_t0;
    logic [W-1:0] z_1_t0, z_0_t0;
    logic [1:0]   err_code_t0;
    logic [15:0]  count_t0;

    logic         in_ack_c3, z_cd_c3, err_c3;
    logic [W-1:0] z_1_c3, z_0_c3;
    logic [1:0]   err_code_c3;
    logic [2:0]   count_c3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dr_logic_stage #(.WIDTH(W), .TIMEOUT(TO), .CNT_W(16)) u_main (
        .clk(clk), .rst(rst), .a_1(a_1), .a_0(a_0), .b_1(b_1), .b_0(b_0), .op(op),
        .in_ack(in_ack), .z_1(z_1), .z_0(z_0), .z_cd(z_cd), .out_ack(out_ack),
        .err(err), .err_code(err_code), .err_clr(err_clr), .count(count));

    dr_logic_stage #(.WIDTH(W), .TIMEOUT(0), .CNT_W(16)) u_t0 (
        .clk(clk), .rst(rst), .a_1(a_1), .a_0(a_0), .b_1(b_1), .b_0(b_0), .op(op),
        .in_ack(in_ack_t0), .z_1(z_1_t0), .z_0(z_0_t0), .z_cd(z_cd_t0), .out_ack(out_ack),
        .err(err_t0), .err_code(err_code_t0), .err_clr(err_clr), .count(count_t0));

    dr_logic_stage #(.WIDTH(W), .TIMEOUT(TO), .CNT_W(3)) u_c3 (
        .clk(clk), .rst(rst), .a_1(a_1), .a_0(a_0), .b_1(b_1), .b_0(b_0), .op(op),
        .in_ack(in_ack_c3), .z_1(z_1_c3), .z_0(z_0_c3), .z_cd(z_cd_c3), .out_ack(out_ack),
        .err(err_c3), .err_code(err_code_c3), .err_clr(err_clr), .count(count_c3));

    // Reference model: phase 0 = ready for a word, 1 = result held, 2 = waiting
    // for the consumer to drop its acknowledge.
    int           m_phase, nx_phase;
    logic [W-1:0] m_z1, m_z0, nx_z1, nx_z0;
    bit           m_ack, nx_ack, m_err, nx_err;
    logic [1:0]   m_code, nx_code;
    int           m_cnt, nx_cnt, m_tmr, nx_tmr;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
        logic [W-1:0] z;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rail_kind(input logic r1, input logic r0);
        if (!r1 && !r0) return 0;
        if (r1 && r0) return 2;
        return 1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_z1 = '0; m_z0 = '0; m_ack = 0;
        m_err = 0; m_code = 2'b00; m_cnt = 0; m_tmr = 0;
    endtask

    task automatic model_eval();
        int nsp, nval, nill, k;
        logic [W-1:0] res;
        bit spc, cmp, prt, tmo;
        logic [1:0] cause;
        nsp = 0; nval = 0; nill = 0;
        for (int i = 0; i < W; i++) begin
            k = rail_kind(a_1[i], a_0[i]);
            if (k == 0) nsp++; else if (k == 1) nval++; else nill++;
            k = rail_kind(b_1[i], b_0[i]);
            if (k == 0) nsp++; else if (k == 1) nval++; else nill++;
            case (op)
                2'b00:   res[i] = a_1[i] & b_1[i];
                2'b01:   res[i] = a_1[i] | b_1[i];
                2'b10:   res[i] = a_1[i] != b_1[i];
                default: res[i] = a_1[i] == b_1[i];
            endcase
        end
        spc = (nsp == 2 * W);
        cmp = (nval == 2 * W);
        prt = !spc && !cmp;
        nx_phase = m_phase; nx_z1 = m_z1; nx_z0 = m_z0; nx_ack = m_ack;
        nx_cnt = m_cnt; nx_err = m_err; nx_code = m_code;
        tmo = 0;
        if (m_phase == 0) begin
            nx_tmr = prt ? ((m_tmr < TO) ? m_tmr + 1 : TO) : 0;
            tmo = (TO > 0) && prt && (nx_tmr == TO);
            if (cmp && !m_ack) begin
                nx_z1 = res; nx_z0 = ~res; nx_ack = 1; nx_phase = 1;
            end
        end else begin
            nx_tmr = 0;
            if (spc) nx_ack = 0;
            if (m_phase == 1 && out_ack) begin
                nx_z1 = '0; nx_z0 = '0; nx_cnt = m_cnt + 1; nx_phase = 2;
            end else if (m_phase == 2 && !out_ack && !m_ack) begin
                nx_phase = 0;
            end
        end
        cause = (nill > 0) ? 2'b01 : (tmo ? 2'b10 : 2'b00);
        if (cause != 2'b00 && (!m_err || err_clr)) begin
            nx_err = 1; nx_code = cause;
        end else if (err_clr) begin
            nx_err = 0; nx_code = 2'b00;
        end
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        #1;
        m_phase = nx_phase; m_z1 = nx_z1; m_z0 = nx_z0; m_ack = nx_ack;
        m_cnt = nx_cnt; m_err = nx_err; m_code = nx_code; m_tmr = nx_tmr;
    endtask

    task automatic check_model();
        chk("rnd_z1", 32'(z_1), 32'(m_z1));
        chk("rnd_z0", 32'(z_0), 32'(m_z0));
        chk("rnd_zcd", 32'(z_cd), 32'(m_phase == 1));
        chk("rnd_in_ack", 32'(in_ack), 32'(m_ack));
        chk("rnd_err", 32'(err), 32'(m_err));
        chk("rnd_err_code", 32'(err_code), 32'(m_code));
        chk("rnd_count", 32'(count), 32'(m_cnt % 65536));
        chk("rnd_count_c3", 32'(count_c3), 32'(m_cnt % 8));
    endtask

    task automatic drive_word(input logic [W-1:0] a, input logic [W-1:0] b);
        a_1 = a; a_0 = ~a; b_1 = b; b_0 = ~b;
    endtask

    task automatic drive_spacer();
        a_1 = '0; a_0 = '0; b_1 = '0; b_0 = '0;
    endtask

    task automatic xact(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] o);
        drive_word(a, b); op = o; tick();
        drive_spacer(); tick();
        out_ack = 1'b1; tick();
        out_ack = 1'b0; tick();
    endtask

    initial begin
        logic [W-1:0] nz;
        int r, k, kb;
        vecs[0] = '{a: 4'b1011, b: 4'b0110, op: 2'b00, z: 4'b0010};
        vecs[1] = '{a: 4'b1100, b: 4'b1010, op: 2'b01, z: 4'b1110};
        vecs[2] = '{a: 4'b1100, b: 4'b1010, op: 2'b10, z: 4'b0110};
        vecs[3] = '{a: 4'b1100, b: 4'b1010, op: 2'b11, z: 4'b1001};

        rst = 1'b1; drive_spacer(); op = 2'b00; out_ack = 1'b0; err_clr = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk("rst_z1", 32'(z_1), 32'(0));
        chk("rst_z0", 32'(z_0), 32'(0));
        chk("rst_zcd", 32'(z_cd), 32'(0));
        chk("rst_in_ack", 32'(in_ack), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_err_code", 32'(err_code), 32'(0));
        chk("rst_count", 32'(count), 32'(0));
        #3 rst = 1'b0;

        // Four-phase transactions from the vector table.
        for (int i = 0; i < 4; i++) begin
            drive_spacer(); tick(); tick();
            drive_word(vecs[i].a, vecs[i].b); op = vecs[i].op; tick();
            nz = ~vecs[i].z;
            chk("vec_z1", 32'(z_1), 32'(vecs[i].z));
            chk("vec_z0", 32'(z_0), 32'(nz));
            chk("vec_zcd", 32'(z_cd), 32'(1));
            chk("vec_in_ack", 32'(in_ack), 32'(1));
            op = ~vecs[i].op; drive_spacer(); tick();
            chk("vec_ack_clr", 32'(in_ack), 32'(0));
            chk("vec_hold_z1", 32'(z_1), 32'(vecs[i].z));
            out_ack = 1'b1; tick();
            chk("vec_rel_z1", 32'(z_1), 32'(0));
            chk("vec_rel_zcd", 32'(z_cd), 32'(0));
            chk("vec_count", 32'(count), 32'(i + 1));
            out_ack = 1'b0; tick();
            chk("vec_no_err", 32'(err), 32'(0));
        end

        // Illegal code on A bit 2, then clear.
        a_1 = 4'b0110; a_0 = 4'b1101; b_1 = 4'b0101; b_0 = 4'b1010; tick();
        chk("ill_err", 32'(err), 32'(1));
        chk("ill_code", 32'(err_code), 32'(1));
        chk("ill_no_capture", 32'(in_ack), 32'(0));
        chk("ill_zcd", 32'(z_cd), 32'(0));
        drive_spacer(); err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("clr_err", 32'(err), 32'(0));
        chk("clr_code", 32'(err_code), 32'(0));

        // Partial word (A complete, B spacer) held until timeout.
        drive_word(4'b1010, 4'b0000); b_1 = '0; b_0 = '0;
        for (int i = 0; i < TO - 1; i++) tick();
        chk("tmo_early", 32'(err), 32'(0));
        tick();
        chk("tmo_err", 32'(err), 32'(1));
        chk("tmo_code", 32'(err_code), 32'(2));
        chk("tmo_disabled", 32'(err_t0), 32'(0));
        chk("tmo_no_capture", 32'(in_ack), 32'(0));
        drive_spacer(); err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("tmo_clr", 32'(err), 32'(0));

        // out_ack rises on the same edge the input returns to spacer.
        drive_word(4'hF, 4'hF); op = 2'b00; tick();
        chk("sim_cap", 32'(in_ack), 32'(1));
        drive_spacer(); out_ack = 1'b1; tick();
        chk("sim_in_ack", 32'(in_ack), 32'(0));
        chk("sim_zcd", 32'(z_cd), 32'(0));
        chk("sim_count", 32'(count), 32'(5));
        drive_word(4'h3, 4'h5); op = 2'b01; tick();
        chk("sim_blocked", 32'(in_ack), 32'(0));
        out_ack = 1'b0; tick();
        chk("sim_drain_exit", 32'(in_ack), 32'(0));
        tick();
        chk("sim_next_ack", 32'(in_ack), 32'(1));
        chk("sim_next_z1", 32'(z_1), 32'(4'h7));
        drive_spacer(); tick(); out_ack = 1'b1; tick(); out_ack = 1'b0; tick();

        // Asynchronous reset while holding 1111.
        drive_word(4'hF, 4'hF); op = 2'b00; tick();
        chk("arst_pre_z1", 32'(z_1), 32'(4'hF));
        #2 rst = 1'b1;
        #1;
        chk("arst_z1", 32'(z_1), 32'(0));
        chk("arst_z0", 32'(z_0), 32'(0));
        chk("arst_zcd", 32'(z_cd), 32'(0));
        chk("arst_in_ack", 32'(in_ack), 32'(0));
        chk("arst_count", 32'(count), 32'(0));
        model_reset(); drive_spacer();
        #1 rst = 1'b0;

        // Counter wrap on the 3-bit instance.
        for (int i = 0; i < 7; i++) xact(4'(i), 4'(i + 3), 2'(i));
        chk("wrap_pre", 32'(count_c3), 32'(7));
        xact(4'h9, 4'h6, 2'b10);
        chk("wrap_zero", 32'(count_c3), 32'(0));
        chk("wrap_main", 32'(count), 32'(8));

        // Randomized run against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 1) == 0) begin
                r = $urandom_range(0, 15);
                if (r < 6) begin
                    drive_spacer();
                end else if (r < 12) begin
                    drive_word(4'($urandom), 4'($urandom));
                end else if (r < 15) begin
                    for (int i = 0; i < W; i++) begin
                        k = $urandom_range(0, 2);
                        kb = $urandom_range(0, 2);
                        a_1[i] = (k == 2); a_0[i] = (k == 1);
                        b_1[i] = (kb == 2); b_0[i] = (kb == 1);
                    end
                end else begin
                    drive_word(4'($urandom), 4'($urandom));
                    k = $urandom_range(0, W - 1);
                    if ($urandom_range(0, 1) == 0) begin
                        a_1[k] = 1'b1; a_0[k] = 1'b1;
                    end else begin
                        b_1[k] = 1'b1; b_0[k] = 1'b1;
                    end
                end
            end
            op = 2'($urandom);
            out_ack = ($urandom_range(0, 1) == 1);
            err_clr = ($urandom_range(0, 9) == 0);
            tick();
            check_model();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
